// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types for the fadd/fsub pipeline controller
// Rounding-mode encoding, pipeline slot record and rm legality helper.
package fp_pkg;

  localparam int MAX_TAG_W = 8;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } rm_e;

  typedef struct packed {
    logic                 v;
    logic                 sub;
    rm_e                  rm;
    logic [MAX_TAG_W-1:0] tag;
  } fadd_slot_t;

  function automatic logic rm_legal(rm_e r);
    return r <= RMM;
  endfunction

endpackage

// File: rtl/fadd_sub_ctrl_if.sv
// rtl/fadd_sub_ctrl_if.sv - issue and writeback handshakes of the fadd/fsub controller
// master = issue/writeback side, slave = controller.
interface fadd_sub_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_sub, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_tag
  );

  modport slave (
    input  in_valid, in_sub, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_tag
  );
endinterface

// File: rtl/fp_rm_resolve.sv
// rtl/fp_rm_resolve.sv - resolves dynamic rm against fcsr.frm and flags illegal modes
module fp_rm_resolve
  import fp_pkg::*;
(
  input  logic [2:0] in_rm,
  input  logic [2:0] frm,
  output rm_e        r,
  output logic       legal
);

  always_comb begin
    r     = (in_rm == DYN) ? rm_e'(frm) : rm_e'(in_rm);
    legal = rm_legal(r);
  end

endmodule

// File: rtl/fadd_sub_ctrl.sv
// rtl/fadd_sub_ctrl.sv - slot pipeline controller for the fadd/fsub datapath
// Carries op/rm/tag beside the datapath stages and generates their load enables.
module fadd_sub_ctrl
  import fp_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  fadd_sub_ctrl_if.slave    io,
  input  logic [2:0]        frm,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic              dp_sub,
  output logic [2:0]        round_rm,
  output logic              illegal_rm,
  output logic [TAG_W-1:0]  err_tag,
  output logic [2:0]        occupancy
);

  logic [STAGES-1:0] v_q, v_d, en;
  rm_e               r;
  logic              legal;
  logic              accept;
  logic              illegal_q;
  logic [TAG_W-1:0]  err_tag_q;
  logic [2:0]        occ_q, occ_d;

  fp_rm_resolve u_rm_resolve (
    .in_rm (io.in_rm),
    .frm   (frm),
    .r     (r),
    .legal (legal)
  );

  assign io.in_ready = en[0] & ~flush & ~reset;
  assign accept      = io.in_valid & io.in_ready;
  assign stage_en    = en;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    fadd_slot_t q, d;

    // A stage may load when it or any stage downstream has a hole, or the tail drains.
    assign en[i]  = io.out_ready | ~(&v_q[STAGES-1:i]);
    assign v_q[i] = q.v;
    assign v_d[i] = d.v;

    if (i == 0) begin : g_head
      always_comb begin
        d = q;
        if (flush) begin
          d.v = 1'b0;
        end else if (en[i]) begin
          d.v = accept & legal;
          if (accept & legal) begin
            d.sub = io.in_sub;
            d.rm  = r;
            d.tag = MAX_TAG_W'(io.in_tag);
          end
        end
      end
    end else begin : g_body
      always_comb begin
        d = q;
        if (flush) begin
          d.v = 1'b0;
        end else if (en[i]) begin
          d = g_slot[i-1].q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + 3'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      err_tag_q <= '0;
      occ_q     <= '0;
    end else begin
      illegal_q <= accept & ~legal;
      if (accept & ~legal) begin
        err_tag_q <= io.in_tag;
      end
      occ_q <= occ_d;
    end
  end

  assign io.out_valid = g_slot[STAGES-1].q.v;
  assign io.out_tag   = g_slot[STAGES-1].q.tag[TAG_W-1:0];
  assign round_rm     = g_slot[STAGES-1].q.rm;
  assign dp_sub       = g_slot[0].q.sub;
  assign illegal_rm   = illegal_q;
  assign err_tag      = err_tag_q;
  assign occupancy    = occ_q;

  // The tail slot's op bit and upper tag bits have no consumer past the round stage.
  logic unused_tail;
  assign unused_tail = ^g_slot[STAGES-1].q;

endmodule

// File: tb/tb_fadd_sub_ctrl.sv
// tb/tb_fadd_sub_ctrl.sv - directed and randomized bench for fadd_sub_ctrl
module tb_fadd_sub_ctrl;

  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        frm;
  logic              flush;
  logic [STAGES-1:0] stage_en;
  logic              dp_sub;
  logic [2:0]        round_rm;
  logic              illegal_rm;
  logic [TAG_W-1:0]  err_tag;
  logic [2:0]        occupancy;

  fadd_sub_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fadd_sub_ctrl #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .io         (bus.slave),
    .frm        (frm),
    .flush      (flush),
    .stage_en   (stage_en),
    .dp_sub     (dp_sub),
    .round_rm   (round_rm),
    .illegal_rm (illegal_rm),
    .err_tag    (err_tag),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [2:0]       rm;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             exp_ill  = 1'b0;
  logic [TAG_W-1:0] exp_err  = '0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input logic v, input logic s, input logic [2:0] rm, input logic [TAG_W-1:0] tg,
                      input logic [2:0] fr, input logic ordy, input logic fl);
    logic       rdy_exp;
    logic [2:0] r;
    exp_t       e;
    @(negedge clk);
    check_eq("occupancy", 32'(occupancy), 32'(sb.size()));
    check_eq("illegal_rm", 32'(illegal_rm), 32'(exp_ill));
    if (exp_ill) check_eq("err_tag", 32'(err_tag), 32'(exp_err));
    bus.in_valid  = v;
    bus.in_sub    = s;
    bus.in_rm     = rm;
    bus.in_tag    = tg;
    frm           = fr;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    rdy_exp = !fl && !(sb.size() == STAGES && !ordy);
    check_eq("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
    exp_ill = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      if (bus.out_valid && ordy) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out_valid", 32'(bus.out_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          check_eq("out_tag", 32'(bus.out_tag), 32'(e.tag));
          check_eq("round_rm", 32'(round_rm), 32'(e.rm));
        end
      end
      if (v && rdy_exp) begin
        r = (rm == 3'b111) ? fr : rm;
        if (r <= 3'd4) begin
          e.tag = tg;
          e.rm  = r;
          sb.push_back(e);
        end else begin
          exp_ill = 1'b1;
          exp_err = tg;
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 3'd0, '0, 3'd0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1'b1);
    check_eq("drain_empty", 32'(sb.size()), 32'(0));
    idle(1'b1);
  endtask

  logic             ov[8];
  logic [TAG_W-1:0] ot[8];
  logic             ds[8];
  logic             found;
  logic [2:0]       occ_before;
  logic             rv, rs, ro, rf;
  logic [2:0]       rrm, rfr;
  int               sel;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; frm = 3'd0;
    bus.in_valid = 1'b0; bus.in_sub = 1'b0; bus.in_rm = 3'd0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_in_ready", 32'(bus.in_ready), 32'(0));
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("reset_occupancy", 32'(occupancy), 32'(0));
    check_eq("reset_illegal", 32'(illegal_rm), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // back-to-back, latency STAGES
    for (int k = 0; k < 8; k++) begin
      if (k < 4) step(1'b1, k[0] ? 1'b0 : 1'b1, 3'd0, TAG_W'(k + 1), 3'd0, 1'b1, 1'b0);
      else idle(1'b1);
      ov[k] = bus.out_valid; ot[k] = bus.out_tag; ds[k] = dp_sub;
    end
    for (int k = 0; k < 8; k++) begin
      check_eq("b2b_valid", 32'(ov[k]), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check_eq("b2b_tag", 32'(ot[k]), 32'(k - 2));
      if (k >= 1 && k <= 4) check_eq("b2b_dp_sub", 32'(ds[k]), 32'(k[0]));
    end

    // backpressure
    drain();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'd1, TAG_W'(10 + k), 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 3'd0, TAG_W'(20), 3'd0, 1'b0, 1'b0);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'(0));
      check_eq("bp_stage_en", 32'(stage_en), 32'(0));
      check_eq("bp_out_tag", 32'(bus.out_tag), 32'(10));
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check_eq("bp_release_valid", 32'(bus.out_valid), 32'(1));
      check_eq("bp_release_tag", 32'(bus.out_tag), 32'(10 + k));
    end

    // dynamic rm
    drain();
    step(1'b1, 1'b0, 3'b111, TAG_W'(7), 3'b010, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      idle(1'b1);
      if (bus.out_valid && bus.out_tag == TAG_W'(7)) begin
        found = 1'b1;
        check_eq("dyn_round_rm", 32'(round_rm), 32'(3'b010));
      end
    end
    check_eq("dyn_emerged", 32'(found), 32'(1));
    drain();
    step(1'b1, 1'b0, 3'b111, TAG_W'(7), 3'b101, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("dyn_illegal", 32'(illegal_rm), 32'(1));
    check_eq("dyn_err_tag", 32'(err_tag), 32'(7));
    for (int k = 0; k < 5; k++) begin
      idle(1'b1);
      check_eq("dyn_no_out", 32'(bus.out_valid), 32'(0));
    end

    // static illegal rm
    drain();
    occ_before = occupancy;
    step(1'b1, 1'b0, 3'b110, TAG_W'(9), 3'd0, 1'b1, 1'b0);
    check_eq("static_ready", 32'(bus.in_ready), 32'(1));
    idle(1'b1);
    check_eq("static_illegal", 32'(illegal_rm), 32'(1));
    check_eq("static_err_tag", 32'(err_tag), 32'(9));
    check_eq("static_occ", 32'(occupancy), 32'(occ_before));
    idle(1'b1);
    check_eq("static_pulse_end", 32'(illegal_rm), 32'(0));

    // flush
    drain();
    step(1'b1, 1'b0, 3'd0, TAG_W'(3), 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd0, TAG_W'(4), 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 3'd0, TAG_W'(5), 3'd0, 1'b1, 1'b1);
    check_eq("flush_in_ready", 32'(bus.in_ready), 32'(0));
    idle(1'b1);
    check_eq("flush_occ", 32'(occupancy), 32'(0));
    check_eq("flush_out_valid", 32'(bus.out_valid), 32'(0));

    // reset mid-stream
    drain();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'd3, TAG_W'(1 + k), 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'(0));
    sb.delete();
    exp_ill = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_out_tag", 32'(bus.out_tag), 32'(0));
    check_eq("rst_round_rm", 32'(round_rm), 32'(0));
    check_eq("rst_dp_sub", 32'(dp_sub), 32'(0));
    check_eq("rst_illegal", 32'(illegal_rm), 32'(0));
    check_eq("rst_err_tag", 32'(err_tag), 32'(0));
    check_eq("rst_occ", 32'(occupancy), 32'(0));
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(1'b1, 1'b0, 3'd3, TAG_W'(21), 3'd0, 1'b1, 1'b0);
      else idle(1'b1);
      check_eq("rst_latency", 32'(bus.out_valid), 32'(k == 3));
    end

    // randomized traffic against the scoreboard
    drain();
    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom % 4) != 0;
      rs  = 1'($urandom % 2);
      sel = int'($urandom % 10);
      if (sel < 7) rrm = 3'($urandom_range(0, 4));
      else if (sel < 9) rrm = 3'b111;
      else rrm = 3'($urandom_range(5, 6));
      rfr = 3'($urandom % 8);
      ro  = ($urandom % 4) != 0;
      rf  = ($urandom % 40) == 0;
      step(rv, rs, rrm, TAG_W'($urandom), rfr, ro, rf);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
